// File: rtl/xm_prefetch_pkg.sv
// xm_prefetch_pkg: shared FSM state, queue entry layout and default constants
// for the XMakina instruction prefetch queue.
package xm_prefetch_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   localparam int XM_WORD = 16;
   localparam int PC_STEP_DEF = 2;
   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

   typedef struct packed {
      logic [XM_WORD-1:0] inst;
      logic [XM_WORD-1:0] pc;
   } fifo_entry_t;

endpackage

// File: rtl/xm_sync_fifo.sv
// xm_sync_fifo: power-of-two synchronous FIFO with flush and registered head.
// Push while full is legal only together with a pop.
module xm_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH+1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd, wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wr] <= din;
            wr <= wr + 1'b1;
         end
         if (pop) rd <= rd + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd];

endmodule

// File: rtl/xm_inst_prefetch.sv
// xm_inst_prefetch: sequential instruction prefetch queue with redirect flush.
// Define XM_PREFETCH_STATS_EN to add saturating fetch/flush/stall counters.
module xm_inst_prefetch
   import xm_prefetch_pkg::*;
#(
   parameter int              WORD     = XM_WORD,
   parameter int              DEPTH    = 4,
   parameter int              PC_STEP  = PC_STEP_DEF,
   parameter logic [WORD-1:0] RESET_PC = WORD'(RESET_PC_DEF),
   localparam int             CW       = $clog2(DEPTH+1)
)(
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic            flush_i,
   input  logic [WORD-1:0] flushPc_i,
   input  logic            memBusy_i,
   input  logic            memDone_i,
   input  logic [WORD-1:0] memData_i,
   output logic            memEn_o,
   output logic [WORD-1:0] memAdr_o,
   output logic [WORD-1:0] inst_o,
   output logic [WORD-1:0] instPc_o,
   output logic            instValid_o,
   input  logic            instReady_i,
`ifdef XM_PREFETCH_STATS_EN
   output logic [15:0]     fetchCnt_o,
   output logic [15:0]     flushCnt_o,
   output logic [15:0]     stallCnt_o,
`endif
   output logic [CW-1:0]   count_o
);

   localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

   state_t          state, state_n;
   logic [WORD-1:0] fetch_pc, pc_n;
   logic [2*WORD-1:0] head;
   logic            push, pop, accept;
   logic [CW:0]     after_pop, after_both;

   assign pop        = instValid_o & instReady_i & ~flush_i;
   assign push       = (state == WAIT) & memDone_i & ~flush_i;
   assign accept     = (state == REQ) & ~memBusy_i;
   assign after_pop  = {1'b0, count_o} - {{CW{1'b0}}, pop};
   assign after_both = after_pop + {{CW{1'b0}}, push};

   xm_sync_fifo #(.WIDTH(2*WORD), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (arst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush_i),
      .din   ({memData_i, fetch_pc}),
      .head  (head),
      .count (count_o)
   );

   assign {inst_o, instPc_o} = head;
   assign instValid_o = count_o != '0;
   assign memEn_o     = state == REQ;
   assign memAdr_o    = fetch_pc;

   // A request accepted in the same cycle as a flush is already in flight, so drain it.
   always_comb begin
      state_n = state;
      pc_n = fetch_pc;
      if (flush_i) begin
         pc_n = flushPc_i;
         state_n = (state == WAIT || state == DRAIN) ? (memDone_i ? REQ : DRAIN) :
                   accept ? DRAIN : REQ;
      end else begin
         case (state)
            IDLE:  state_n = after_pop < FULL ? REQ : IDLE;
            REQ:   state_n = memBusy_i ? REQ : WAIT;
            WAIT:  begin
               state_n = memDone_i ? (after_both < FULL ? REQ : IDLE) : WAIT;
               pc_n = memDone_i ? fetch_pc + WORD'(PC_STEP) : fetch_pc;
            end
            DRAIN: state_n = memDone_i ? REQ : DRAIN;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_n;
         fetch_pc <= pc_n;
      end
   end

`ifdef XM_PREFETCH_STATS_EN
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         fetchCnt_o <= '0;
         flushCnt_o <= '0;
         stallCnt_o <= '0;
      end else begin
         if (accept && ~&fetchCnt_o) fetchCnt_o <= fetchCnt_o + 1'b1;
         if (flush_i && ~&flushCnt_o) flushCnt_o <= flushCnt_o + 1'b1;
         if (instReady_i && !instValid_o && ~&stallCnt_o) stallCnt_o <= stallCnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_xm_inst_prefetch.sv
// tb_xm_inst_prefetch: directed vector table plus hand sequences for reset,
// late completion after reset and address wrap.
module tb_xm_inst_prefetch;

   logic        clk_i = 1'b0;
   logic        arst_i = 1'b1;
   logic        flush_i = 1'b0;
   logic [15:0] flushPc_i = '0;
   logic        memBusy_i = 1'b0;
   logic        memDone_i = 1'b0;
   logic [15:0] memData_i = '0;
   logic        memEn_o;
   logic [15:0] memAdr_o, inst_o, instPc_o;
   logic        instValid_o;
   logic        instReady_i = 1'b0;
   logic [2:0]  count_o;
`ifdef XM_PREFETCH_STATS_EN
   logic [15:0] fetchCnt_o, flushCnt_o, stallCnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   xm_inst_prefetch dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .flush_i     (flush_i),
      .flushPc_i   (flushPc_i),
      .memBusy_i   (memBusy_i),
      .memDone_i   (memDone_i),
      .memData_i   (memData_i),
      .memEn_o     (memEn_o),
      .memAdr_o    (memAdr_o),
      .inst_o      (inst_o),
      .instPc_o    (instPc_o),
      .instValid_o (instValid_o),
      .instReady_i (instReady_i),
`ifdef XM_PREFETCH_STATS_EN
      .fetchCnt_o  (fetchCnt_o),
      .flushCnt_o  (flushCnt_o),
      .stallCnt_o  (stallCnt_o),
`endif
      .count_o     (count_o)
   );

   typedef struct {
      logic        fl;
      logic [15:0] fpc;
      logic        busy;
      logic        done;
      logic [15:0] data;
      logic        rdy;
      logic        en;
      logic [15:0] adr;
      logic        vld;
      logic [15:0] inst;
      logic [15:0] ipc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic fl, input logic [15:0] fpc, input logic busy, input logic done,
                      input logic [15:0] data, input logic rdy, input logic en, input logic [15:0] adr,
                      input logic vld, input logic [15:0] inst, input logic [15:0] ipc, input logic [2:0] cnt);
      vq.push_back('{fl, fpc, busy, done, data, rdy, en, adr, vld, inst, ipc, cnt});
   endtask

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic [15:0] fpc, input logic busy,
                        input logic done, input logic [15:0] data, input logic rdy);
      flush_i = fl;
      flushPc_i = fpc;
      memBusy_i = busy;
      memDone_i = done;
      memData_i = data;
      instReady_i = rdy;
   endtask

   task automatic chk_core(input string nm, input logic en, input logic [15:0] adr,
                           input logic vld, input logic [2:0] cnt);
      chk({nm, " memEn"}, 16'(memEn_o), 16'(en));
      chk({nm, " memAdr"}, memAdr_o, adr);
      chk({nm, " valid"}, 16'(instValid_o), 16'(vld));
      chk({nm, " count"}, 16'(count_o), 16'(cnt));
   endtask

   initial begin
      //   fl fpc      bsy dn data      rdy | en adr      vld inst      ipc      cnt
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 1, 16'hA000, 0,   0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0002, 1, 16'hA000, 16'h0000, 1);
      add(0, 16'h0000, 0, 1, 16'hA001, 0,   0, 16'h0002, 1, 16'hA000, 16'h0000, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0004, 1, 16'hA000, 16'h0000, 2);
      add(0, 16'h0000, 0, 1, 16'hA002, 0,   0, 16'h0004, 1, 16'hA000, 16'h0000, 2);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0006, 1, 16'hA000, 16'h0000, 3);
      add(0, 16'h0000, 0, 1, 16'hA003, 0,   0, 16'h0006, 1, 16'hA000, 16'h0000, 3);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0008, 1, 16'hA000, 16'h0000, 4);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0008, 1, 16'hA000, 16'h0000, 4);
      add(0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0008, 1, 16'hA000, 16'h0000, 4);
      add(0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0008, 1, 16'hA001, 16'h0002, 3);
      add(0, 16'h0000, 0, 1, 16'hA004, 1,   0, 16'h0008, 1, 16'hA002, 16'h0004, 2);
      add(0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h000A, 1, 16'hA003, 16'h0006, 2);
      add(0, 16'h0000, 0, 1, 16'hA005, 1,   0, 16'h000A, 1, 16'hA004, 16'h0008, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h000C, 1, 16'hA005, 16'h000A, 1);
      add(0, 16'h0000, 0, 1, 16'hA006, 0,   0, 16'h000C, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h000E, 1, 16'hA006, 16'h000C, 1);
      add(1, 16'h0100, 0, 0, 16'h0000, 0,   0, 16'h000E, 1, 16'hA006, 16'h000C, 1);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0100, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 1, 16'hDEAD, 0,   0, 16'h0100, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0100, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 1, 16'hB000, 0,   0, 16'h0100, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0102, 1, 16'hB000, 16'h0100, 1);
      add(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0102, 1, 16'hB000, 16'h0100, 1);
      add(1, 16'h0200, 1, 0, 16'h0000, 0,   1, 16'h0102, 1, 16'hB000, 16'h0100, 1);
      add(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0200, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0200, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0200, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 1, 16'hC000, 0,   0, 16'h0200, 0, 16'h0000, 16'h0000, 0);
      add(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0202, 1, 16'hC000, 16'h0200, 1);

      #1;
      chk_core("reset", 0, 16'h0000, 0, 0);
      chk("reset inst", inst_o, 16'h0000);
      chk("reset instPc", instPc_o, 16'h0000);
      @(negedge clk_i);
      arst_i = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].fl, vq[i].fpc, vq[i].busy, vq[i].done, vq[i].data, vq[i].rdy);
         #1;
         chk_core($sformatf("v%0d", i), vq[i].en, vq[i].adr, vq[i].vld, vq[i].cnt);
         if (vq[i].vld) begin
            chk($sformatf("v%0d inst", i), inst_o, vq[i].inst);
            chk($sformatf("v%0d instPc", i), instPc_o, vq[i].ipc);
         end
         @(negedge clk_i);
      end

      // Reset mid-fetch, then a late completion that must be ignored.
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      #2 arst_i = 1'b1;
      #1;
      chk_core("midreset", 0, 16'h0000, 0, 0);
      chk("midreset inst", inst_o, 16'h0000);
      @(negedge clk_i);
      arst_i = 1'b0;
      drive(0, 16'h0000, 0, 1, 16'hEEEE, 0);
      #1 chk_core("late done", 0, 16'h0000, 0, 0);
      @(negedge clk_i);
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      #1 chk_core("after late", 1, 16'h0000, 0, 0);

      // Retarget a busy request to 0xFFFE and check the wrap to 0x0000.
      drive(1, 16'hFFFE, 1, 0, 16'h0000, 0);
      @(negedge clk_i);
      drive(0, 16'h0000, 0, 0, 16'h0000, 0);
      #1 chk_core("wrap req", 1, 16'hFFFE, 0, 0);
      @(negedge clk_i);
      drive(0, 16'h0000, 0, 1, 16'h1234, 0);
      #1 chk_core("wrap wait", 0, 16'hFFFE, 0, 0);
      @(negedge clk_i);
      drive(0, 16'h0000, 1, 0, 16'h0000, 0);
      #1 chk_core("wrap next", 1, 16'h0000, 1, 1);
      chk("wrap inst", inst_o, 16'h1234);
      chk("wrap instPc", instPc_o, 16'hFFFE);

`ifdef XM_PREFETCH_STATS_EN
      @(negedge clk_i);
      arst_i = 1'b1;
      #1 chk("stats reset flush", flushCnt_o, 16'h0000);
      @(negedge clk_i);
      arst_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(1, 16'h0300, 1, 0, 16'h0000, 1);
         @(negedge clk_i);
         drive(0, 16'h0000, 1, 0, 16'h0000, 1);
         @(negedge clk_i);
      end
      repeat (70000) @(negedge clk_i);
      #1;
      chk("stats flush", flushCnt_o, 16'd3);
      chk("stats stall", stallCnt_o, 16'hFFFF);
      chk("stats fetch", fetchCnt_o, 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
